// File: rtl/prime_seek_pkg.sv
// Shared definitions for the prime search engine.
//   state_e      : controller states
//   DIR_UP/DOWN  : encodings of the search direction input
//   rem_latency  : cycles from remainder-unit launch to rem_valid
package prime_seek_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_DIVIDE = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // One load cycle followed by one cycle per quotient bit.
    function automatic int unsigned rem_latency(input int unsigned width);
        return width + 32'd1;
    endfunction

endpackage

// File: rtl/prime_rem_unit.sv
// Restoring remainder divider, one quotient bit per cycle.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_go                 : launch strobe, captures dividend and divisor
//   i_dividend/i_divisor : operands (divisor must be non-zero)
//   o_rem                : remainder, valid from o_rem_valid until next i_go
//   o_rem_valid          : one-cycle pulse, rem_latency(WIDTH) cycles after launch
module prime_rem_unit
    import prime_seek_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_go,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_rem_valid
);

    localparam int unsigned STEPS = rem_latency(WIDTH) - 32'd1;
    localparam int          CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_next;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    // The difference is always below the divisor, so the low WIDTH bits suffice.
    always_comb begin
        w_shift = {r_rem, r_dvd[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_dvs});
        w_sub   = w_shift[WIDTH-1:0] - r_dvs;
        if (w_ge) begin
            w_rem_next = w_sub;
        end else begin
            w_rem_next = w_shift[WIDTH-1:0];
        end
    end

    // Operand capture, bit-serial iteration and the completion pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem   <= {WIDTH{1'b0}};
            r_dvd   <= {WIDTH{1'b0}};
            r_dvs   <= {WIDTH{1'b0}};
            r_cnt   <= CNT_ZERO;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_go) begin
                r_rem <= {WIDTH{1'b0}};
                r_dvd <= i_dividend;
                r_dvs <= i_divisor;
                r_cnt <= CNT_LOAD;
            end else if (r_cnt != CNT_ZERO) begin
                r_rem <= w_rem_next;
                r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign o_rem       = r_rem;
    assign o_rem_valid = r_valid;

endmodule

// File: rtl/prime_seek_engine.sv
// Nearest-prime search: from a seed, steps up or down (wrapping at LIMIT / 2)
// until a prime is found, using odd trial division via prime_rem_unit.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : request, sampled only while idle
//   i_num_in       : seed, captured with i_start
//   i_dir          : 0 = search upward, 1 = downward
//   i_inclusive    : 1 = the seed itself may be the answer
//   o_busy         : high from the cycle after acceptance through the done cycle
//   o_done         : one-cycle result strobe
//   o_prime_out    : result, held until the next o_done
//   o_wrapped      : search crossed the wrap boundary, held with o_prime_out
module prime_seek_engine
    import prime_seek_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter int unsigned LIMIT = 2**WIDTH - 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_num_in,
    input  logic             i_dir,
    input  logic             i_inclusive,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prime_out,
    output logic             o_wrapped
);

    localparam logic [WIDTH-1:0] LIM   = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ZERO  = WIDTH'(32'd0);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(32'd2);
    localparam logic [WIDTH-1:0] THREE = WIDTH'(32'd3);
    localparam logic [WIDTH-1:0] FOUR  = WIDTH'(32'd4);

    state_e           r_state;
    logic [WIDTH-1:0] r_seed;
    logic             r_dir;
    logic             r_incl;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_fac;
    logic             r_wrap;
    logic             r_launch;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_prime;
    logic             r_wrapped;

    state_e             w_state_next;
    logic [WIDTH-1:0]   w_cand_next;
    logic [WIDTH-1:0]   w_fac_next;
    logic               w_wrap_next;
    logic               w_launch_next;
    logic               w_capture;
    logic               w_go;
    logic [WIDTH-1:0]   w_rem;
    logic               w_rem_valid;
    logic [WIDTH:0]     w_up;
    logic [WIDTH-1:0]   w_fac_inc;
    logic [2*WIDTH-1:0] w_fac_sq;

    prime_rem_unit #(
        .WIDTH (WIDTH)
    ) u_rem (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_go        (w_go),
        .i_dividend  (r_cand),
        .i_divisor   (r_fac),
        .o_rem       (w_rem),
        .o_rem_valid (w_rem_valid)
    );

    // Stepping and square-compare datapath; the upward step keeps its carry so
    // a candidate of 2**WIDTH-1 still detects crossing LIMIT.
    always_comb begin
        w_up      = {1'b0, r_cand} + {{WIDTH{1'b0}}, 1'b1};
        w_fac_inc = r_fac + TWO;
        w_fac_sq  = {{WIDTH{1'b0}}, w_fac_inc} * {{WIDTH{1'b0}}, w_fac_inc};
    end

    // Controller next-state and datapath register updates.
    always_comb begin
        w_state_next  = r_state;
        w_cand_next   = r_cand;
        w_fac_next    = r_fac;
        w_wrap_next   = r_wrap;
        w_launch_next = 1'b0;
        w_capture     = 1'b0;
        w_go          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_capture    = 1'b1;
                    w_wrap_next  = 1'b0;
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (r_seed > LIM) begin
                    // Out-of-range seed restarts at the far end and is tested as-is.
                    w_cand_next  = (r_dir == DIR_DOWN) ? LIM : TWO;
                    w_wrap_next  = 1'b1;
                    w_state_next = ST_CHECK;
                end else if (r_incl) begin
                    w_cand_next  = r_seed;
                    w_state_next = ST_CHECK;
                end else begin
                    w_cand_next  = r_seed;
                    w_state_next = ST_NEXT;
                end
            end
            ST_CHECK: begin
                if (r_cand < TWO) begin
                    w_state_next = ST_NEXT;
                end else if (r_cand < FOUR) begin
                    w_state_next = ST_DONE;
                end else if (!r_cand[0]) begin
                    w_state_next = ST_NEXT;
                end else begin
                    w_fac_next    = THREE;
                    w_launch_next = 1'b1;
                    w_state_next  = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                // r_launch marks the first cycle of each trial division.
                w_go = r_launch;
                if (w_rem_valid) begin
                    if (w_rem == ZERO) begin
                        w_state_next = ST_NEXT;
                    end else begin
                        w_fac_next = w_fac_inc;
                        if (w_fac_sq > {{WIDTH{1'b0}}, r_cand}) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_launch_next = 1'b1;
                            w_state_next  = ST_DIVIDE;
                        end
                    end
                end else begin
                    w_state_next = ST_DIVIDE;
                end
            end
            ST_NEXT: begin
                if (r_dir == DIR_DOWN) begin
                    if (r_cand < THREE) begin
                        w_cand_next = LIM;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_cand_next = r_cand - ONE;
                    end
                end else begin
                    if (w_up > {1'b0, LIM}) begin
                        w_cand_next = TWO;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_cand_next = w_up[WIDTH-1:0];
                    end
                end
                w_state_next = ST_CHECK;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_seed    <= ZERO;
            r_dir     <= 1'b0;
            r_incl    <= 1'b0;
            r_cand    <= ZERO;
            r_fac     <= ZERO;
            r_wrap    <= 1'b0;
            r_launch  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_prime   <= ZERO;
            r_wrapped <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cand   <= w_cand_next;
            r_fac    <= w_fac_next;
            r_wrap   <= w_wrap_next;
            r_launch <= w_launch_next;
            if (w_capture) begin
                r_seed <= i_num_in;
                r_dir  <= i_dir;
                r_incl <= i_inclusive;
            end
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= (w_state_next == ST_DONE);
            if (w_state_next == ST_DONE) begin
                r_prime   <= w_cand_next;
                r_wrapped <= w_wrap_next;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_prime_out = r_prime;
    assign o_wrapped   = r_wrapped;

endmodule

// File: tb/tb_prime_seek_engine.sv
// Self-checking bench for prime_seek_engine (WIDTH=8, LIMIT=255): a driver pushes
// reference-model expectations into a scoreboard queue, a monitor pops on o_done.
module tb_prime_seek_engine;

    localparam int W   = 8;
    localparam int LIM = 255;
    localparam int TMO = 5000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] num_in = '0;
    logic         dir = 1'b0;
    logic         incl = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] prime_out;
    logic         wrapped;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_done = 1'b0;

    typedef struct {
        int prime;
        int wrap;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];

    prime_seek_engine #(.WIDTH(W), .LIMIT(LIM)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_num_in    (num_in),
        .i_dir       (dir),
        .i_inclusive (incl),
        .o_busy      (busy),
        .o_done      (done),
        .o_prime_out (prime_out),
        .o_wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int next_cand(input int c, input bit dn, output bit wr);
        wr = 1'b0;
        if (!dn) begin
            if (c + 1 > LIM) begin
                wr = 1'b1;
                return 2;
            end
            return c + 1;
        end
        if (c - 1 < 2) begin
            wr = 1'b1;
            return LIM;
        end
        return c - 1;
    endfunction

    // Result, wrap flag and cycles from acceptance to the done cycle (inclusive):
    // LOAD 1, optional initial step 1, per candidate CHECK 1, each trial division
    // W+2, each step 1, DONE 1.
    function automatic exp_t model(input int seed, input bit dn, input bit inc);
        exp_t e;
        int c;
        int lat;
        int f;
        bit w;
        bit wr;
        w = 1'b0;
        lat = 1;
        if (seed > LIM) begin
            c = dn ? LIM : 2;
            w = 1'b1;
        end else begin
            c = seed;
            if (!inc) begin
                lat++;
                c = next_cand(c, dn, wr);
                w = w | wr;
            end
        end
        for (int guard = 0; guard < 1000; guard++) begin
            lat++;
            if (c >= 5 && (c % 2) == 1) begin
                f = 3;
                do begin
                    lat += W + 2;
                    if (c % f == 0) break;
                    f += 2;
                end while (f * f <= c);
            end
            if (is_prime(c)) break;
            lat++;
            c = next_cand(c, dn, wr);
            w = w | wr;
        end
        lat++;
        e.prime = c;
        e.wrap  = int'(w);
        e.lat   = lat;
        e.acc   = 0;
        return e;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after acceptance.
    // exp_p < 0 takes the result from the model, otherwise from the caller.
    task automatic issue(input int seed, input bit dn, input bit inc,
                         input bit expect_done, input int exp_p, input int exp_w);
        exp_t e;
        int t;
        t = 0;
        while (busy && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", int'(busy), 0);
        start  = 1'b1;
        num_in = W'(seed);
        dir    = dn;
        incl   = inc;
        @(negedge clk);
        start = 1'b0;
        if (expect_done) begin
            e = model(seed, dn, inc);
            if (exp_p >= 0) begin
                e.prime = exp_p;
                e.wrap  = exp_w;
            end
            e.acc = cyc;
            sb.push_back(e);
        end
        check("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", int'(done), 1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done_single_cycle", int'(prev_done), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: prime_out=%0d with no request pending", prime_out);
            end else begin
                e = sb.pop_front();
                check("prime_out", int'(prime_out), e.prime);
                check("wrapped", int'(wrapped), e.wrap);
                check("latency", cyc - e.acc + 1, e.lat);
            end
        end
        prev_done <= done;
    end

    // ---------------- stimulus ----------------
    initial begin
        int seeds[256];
        int j;
        int tmp;

        #2 rst_n = 1'b0;
        #10;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_prime_out", int'(prime_out), 0);
        check("rst_wrapped", int'(wrapped), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with explicitly known answers.
        issue(14, 1'b0, 1'b0, 1'b1, 17, 0);
        issue(13, 1'b0, 1'b1, 1'b1, 13, 0);
        issue(13, 1'b0, 1'b0, 1'b1, 17, 0);
        issue(14, 1'b1, 1'b0, 1'b1, 13, 0);
        issue(2,  1'b0, 1'b1, 1'b1, 2, 0);
        issue(251, 1'b0, 1'b0, 1'b1, 2, 1);
        issue(2,  1'b1, 1'b0, 1'b1, 251, 1);

        // Start pulsed while busy is ignored.
        issue(100, 1'b0, 1'b0, 1'b1, 101, 0);
        @(negedge clk);
        @(negedge clk);
        check("busy_before_ignored_start", int'(busy), 1);
        start  = 1'b1;
        num_in = W'(7);
        dir    = 1'b1;
        incl   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Back-to-back: start in the cycle right after done.
        issue(20, 1'b0, 1'b1, 1'b1, 23, 0);
        wait_done();
        @(negedge clk);
        check("b2b_busy_low", int'(busy), 0);
        issue(24, 1'b1, 1'b0, 1'b1, 23, 0);
        wait_done();

        // Asynchronous abort in the middle of a trial division.
        issue(250, 1'b0, 1'b0, 1'b0, -1, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_prime_out", int'(prime_out), 0);
        check("abort_wrapped", int'(wrapped), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("idle_after_abort", int'(busy), 0);
        issue(89, 1'b0, 1'b1, 1'b1, 89, 0);
        wait_done();

        // Every seed once, shuffled, with random direction and inclusivity.
        for (int i = 0; i < 256; i++) seeds[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = seeds[i];
            seeds[i] = seeds[j];
            seeds[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            issue(seeds[i], 1'($urandom), 1'($urandom), 1'b1, -1, 0);
        end
        for (int i = 0; i < 150; i++) begin
            issue(int'($urandom_range(255, 0)), 1'($urandom), 1'($urandom), 1'b1, -1, 0);
        end
        wait_done();
        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
